// File: rtl/idma_xif_txn_scheduler.sv
// Transfer scheduler for Xif-decoded iDMA commands: per-direction command queues,
// transfer ID assignment, round-robin issue to the frontend, in-order completion tracking.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no request held; waiting for a queued command and credit
// S_ISSUE | request register valid on req_*, waiting for req_ready_i
module idma_xif_txn_scheduler #(
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 32,
    parameter int ID_W            = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_dir_i,
    input  logic [ADDR_W-1:0] cmd_src_i,
    input  logic [ADDR_W-1:0] cmd_dst_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    output logic [ID_W-1:0]   cmd_id_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_dir_o,
    output logic [ADDR_W-1:0] req_src_o,
    output logic [ADDR_W-1:0] req_dst_o,
    output logic [LEN_W-1:0]  req_len_o,
    output logic [ID_W-1:0]   req_id_o,
    input  logic              rsp_valid_i,
    input  logic              rsp_error_i,
    output logic              done_valid_o,
    output logic [ID_W-1:0]   done_id_o,
    output logic              err_o,
    input  logic              clr_err_i,
    output logic              busy_o
);

    localparam int QW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int QCW = $clog2(QUEUE_DEPTH + 1);
    localparam int TW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } entry_t;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t          state;
    logic            rr_dir;
    logic [ID_W-1:0] next_id;
    logic [OW-1:0]   outstanding;

    entry_t          q_mem [2][QUEUE_DEPTH];
    logic [QW-1:0]   q_wr [2];
    logic [QW-1:0]   q_rd [2];
    logic [QCW-1:0]  q_cnt [2];
    entry_t          q_head [2];
    logic [1:0]      q_empty;
    logic [1:0]      q_full;
    logic [1:0]      q_push;
    logic [1:0]      q_pop;

    logic [ID_W-1:0] trk_mem [MAX_OUTSTANDING];
    logic [TW-1:0]   trk_wr;
    logic [TW-1:0]   trk_rd;

    logic            req_hs;
    logic            rsp_acc;
    logic            can_grant;
    logic            gnt_dir;
    entry_t          gnt_entry;
    logic [OW:0]     out_eff;

    function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
        return (p == QW'(QUEUE_DEPTH - 1)) ? '0 : p + QW'(1);
    endfunction

    function automatic logic [TW-1:0] t_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            q_empty[d] = (q_cnt[d] == '0);
            q_full[d]  = (q_cnt[d] == QCW'(QUEUE_DEPTH));
            q_head[d]  = q_mem[d][q_rd[d]];
        end
    end

    assign cmd_ready_o = !q_full[cmd_dir_i];
    assign cmd_id_o    = next_id;

    assign req_hs  = (state == S_ISSUE) && req_ready_i;
    assign rsp_acc = rsp_valid_i && (outstanding != '0);

    // Credit check includes the request retiring this cycle so back-to-back issue never overshoots.
    assign out_eff   = {1'b0, outstanding} + {{OW{1'b0}}, req_hs};
    assign can_grant = ((state == S_IDLE) || req_hs)
                       && (out_eff < (OW+1)'(MAX_OUTSTANDING))
                       && !(&q_empty);
    assign gnt_dir   = q_empty[0] ? 1'b1 : (q_empty[1] ? 1'b0 : rr_dir);
    assign gnt_entry = q_head[gnt_dir];

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            q_push[d] = cmd_valid_i && cmd_ready_o && (cmd_dir_i == d[0]);
            q_pop[d]  = can_grant && (gnt_dir == d[0]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            next_id <= '0;
            for (int d = 0; d < 2; d++) begin
                q_wr[d]  <= '0;
                q_rd[d]  <= '0;
                q_cnt[d] <= '0;
            end
        end else begin
            if (cmd_valid_i && cmd_ready_o) begin
                next_id <= next_id + ID_W'(1);
            end
            for (int d = 0; d < 2; d++) begin
                if (q_push[d]) begin
                    q_mem[d][q_wr[d]] <= '{src: cmd_src_i, dst: cmd_dst_i, len: cmd_len_i, id: next_id};
                    q_wr[d]           <= q_next(q_wr[d]);
                end
                if (q_pop[d]) begin
                    q_rd[d] <= q_next(q_rd[d]);
                end
                if (q_push[d] && !q_pop[d]) begin
                    q_cnt[d] <= q_cnt[d] + QCW'(1);
                end else if (!q_push[d] && q_pop[d]) begin
                    q_cnt[d] <= q_cnt[d] - QCW'(1);
                end
            end
        end
    end

    // In-order ID tracker; its occupancy always equals outstanding.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            trk_wr <= '0;
            trk_rd <= '0;
        end else begin
            if (req_hs) begin
                trk_mem[trk_wr] <= req_id_o;
                trk_wr          <= t_next(trk_wr);
            end
            if (rsp_acc) begin
                trk_rd <= t_next(trk_rd);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            rr_dir       <= 1'b0;
            outstanding  <= '0;
            req_valid_o  <= 1'b0;
            req_dir_o    <= 1'b0;
            req_src_o    <= '0;
            req_dst_o    <= '0;
            req_len_o    <= '0;
            req_id_o     <= '0;
            done_valid_o <= 1'b0;
            done_id_o    <= '0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            if (can_grant) begin
                state       <= S_ISSUE;
                req_valid_o <= 1'b1;
                req_dir_o   <= gnt_dir;
                req_src_o   <= gnt_entry.src;
                req_dst_o   <= gnt_entry.dst;
                req_len_o   <= gnt_entry.len;
                req_id_o    <= gnt_entry.id;
                rr_dir      <= !gnt_dir;
            end else if (req_hs) begin
                state       <= S_IDLE;
                req_valid_o <= 1'b0;
            end

            if (req_hs && !rsp_acc) begin
                outstanding <= outstanding + OW'(1);
            end else if (!req_hs && rsp_acc) begin
                outstanding <= outstanding - OW'(1);
            end

            done_valid_o <= rsp_acc;
            if (rsp_acc) begin
                done_id_o <= trk_mem[trk_rd];
            end

            if (rsp_acc && rsp_error_i) begin
                err_o <= 1'b1;
            end else if (clr_err_i) begin
                err_o <= 1'b0;
            end

            busy_o <= !(&q_empty) || (state == S_ISSUE) || (outstanding != '0);
        end
    end

endmodule

// File: tb/tb_idma_xif_txn_scheduler.sv
// Self-checking bench for idma_xif_txn_scheduler: scoreboard of expected issues and
// completions, plus per-scenario cycle-accurate checks.
module tb_idma_xif_txn_scheduler;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [31:0] cmd_src;
    logic [31:0] cmd_dst;
    logic [31:0] cmd_len;
    logic [7:0]  cmd_id;
    logic        req_valid;
    logic        req_ready;
    logic        req_dir;
    logic [31:0] req_src;
    logic [31:0] req_dst;
    logic [31:0] req_len;
    logic [7:0]  req_id;
    logic        rsp_valid;
    logic        rsp_error;
    logic        done_valid;
    logic [7:0]  done_id;
    logic        err;
    logic        clr_err;
    logic        busy;

    always #5 clk = ~clk;

    idma_xif_txn_scheduler #(
        .QUEUE_DEPTH(4), .MAX_OUTSTANDING(4), .ADDR_W(32), .LEN_W(32), .ID_W(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_dir_i(cmd_dir),
        .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len), .cmd_id_o(cmd_id),
        .req_valid_o(req_valid), .req_ready_i(req_ready), .req_dir_o(req_dir),
        .req_src_o(req_src), .req_dst_o(req_dst), .req_len_o(req_len), .req_id_o(req_id),
        .rsp_valid_i(rsp_valid), .rsp_error_i(rsp_error),
        .done_valid_o(done_valid), .done_id_o(done_id),
        .err_o(err), .clr_err_i(clr_err), .busy_o(busy)
    );

    typedef struct {
        logic        dir;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic [7:0]  id;
    } txn_t;

    txn_t       exp_issue_q[$];
    logic [7:0] exp_done_q[$];
    txn_t       mon_e;
    logic [7:0] mon_id;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_issued = 0;
    logic [7:0] exp_next_id = 8'd0;

    // Scoreboard: every frontend handshake and completion pulse is matched against expectations.
    always @(negedge clk) begin
        if (rst_ni && req_valid && req_ready) begin
            n_checks++;
            n_issued++;
            if (exp_issue_q.size() == 0) begin
                n_errors++;
                $display("FAIL issue_unexpected: got id %0d, required no issue", req_id);
            end else begin
                mon_e = exp_issue_q.pop_front();
                if ({req_dir, req_src, req_dst, req_len, req_id} !==
                    {mon_e.dir, mon_e.src, mon_e.dst, mon_e.len, mon_e.id}) begin
                    n_errors++;
                    $display("FAIL issue_payload: got dir=%b src=%h dst=%h len=%0d id=%0d, required dir=%b src=%h dst=%h len=%0d id=%0d",
                             req_dir, req_src, req_dst, req_len, req_id,
                             mon_e.dir, mon_e.src, mon_e.dst, mon_e.len, mon_e.id);
                end
                exp_done_q.push_back(mon_e.id);
            end
        end
        if (rst_ni && done_valid) begin
            n_checks++;
            if (exp_done_q.size() == 0) begin
                n_errors++;
                $display("FAIL done_unexpected: got id %0d, required no completion", done_id);
            end else begin
                mon_id = exp_done_q.pop_front();
                if (done_id !== mon_id) begin
                    n_errors++;
                    $display("FAIL done_id: got %0d, required %0d", done_id, mon_id);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        clr_err   = 1'b0;
        tick();
        tick();
        exp_issue_q.delete();
        exp_done_q.delete();
        exp_next_id = 8'd0;
        n_issued    = 0;
        rst_ni      = 1'b1;
    endtask

    task automatic send_cmd(input logic dir, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len, input bit push);
        int   k;
        txn_t t;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        #1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        n_checks++;
        if (!cmd_ready) begin
            n_errors++;
            $display("FAIL cmd_accept_timeout: ready %b, required 1", cmd_ready);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end else begin
            n_checks++;
            if (cmd_id !== exp_next_id) begin
                n_errors++;
                $display("FAIL cmd_id: got %0d, required %0d", cmd_id, exp_next_id);
            end
            if (push) begin
                t = '{dir, src, dst, len, exp_next_id};
                exp_issue_q.push_back(t);
            end
            @(posedge clk);
            #1;
            cmd_valid   = 1'b0;
            exp_next_id = exp_next_id + 8'd1;
        end
    endtask

    task automatic wait_issued(input int budget);
        int k;
        k = 0;
        while (exp_issue_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (exp_issue_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: %0d pending, required 0", exp_issue_q.size());
        end
    endtask

    task automatic drain();
        int k;
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        k = 0;
        while ((exp_issue_q.size() != 0 || exp_done_q.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        rsp_valid = 1'b0;
        n_checks++;
        if (exp_issue_q.size() != 0 || exp_done_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d issues and %0d completions pending, required 0",
                     exp_issue_q.size(), exp_done_q.size());
        end
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({req_valid, req_dir, req_src, req_dst, req_len, req_id} !== '0) begin
            n_errors++;
            $display("FAIL reset_req: got valid=%b src=%h id=%0d, required all 0", req_valid, req_src, req_id);
        end
        n_checks++;
        if ({done_valid, done_id, err, busy} !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_status: got done=%b id=%0d err=%b busy=%b, required all 0",
                     done_valid, done_id, err, busy);
        end
        n_checks++;
        if (cmd_ready !== 1'b1 || cmd_id !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_cmd: got ready=%b id=%0d, required ready=1 id=0", cmd_ready, cmd_id);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_ready = 1'b1;
        send_cmd(1'b0, 32'h1000, 32'h2000, 32'd64, 1'b1);
        n_checks++;
        if (req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_lat_n1: req_valid %b, required 0", req_valid);
        end
        tick();
        n_checks++;
        if (req_valid !== 1'b1 || req_src !== 32'h1000 || req_dst !== 32'h2000 ||
            req_len !== 32'd64 || req_id !== 8'd0) begin
            n_errors++;
            $display("FAIL single_lat_n2: valid=%b src=%h dst=%h len=%0d id=%0d, required 1 1000 2000 64 0",
                     req_valid, req_src, req_dst, req_len, req_id);
        end
        tick();
        tick();
        tick();
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        n_checks++;
        if (done_valid !== 1'b1 || done_id !== 8'd0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_done: done=%b id=%0d busy=%b, required 1 0 1", done_valid, done_id, busy);
        end
        tick();
        n_checks++;
        if (done_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_busy_fall: done=%b busy=%b, required 0 0", done_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int k;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_cmd(i[0], 32'h3000 + 32'(i * 16), 32'h8000 + 32'(i * 16), 32'(i + 1), 1'b1);
        end
        tick();
        n_checks++;
        if (req_valid !== 1'b1 || req_id !== 8'd0) begin
            n_errors++;
            $display("FAIL rr_first_held: valid=%b id=%0d, required 1 0", req_valid, req_id);
        end
        req_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_checks++;
        if (n_issued !== 4 || req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rr_stall: issued %0d valid=%b, required 4 0", n_issued, req_valid);
        end
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        n_checks++;
        if (done_valid !== 1'b1 || done_id !== 8'd0) begin
            n_errors++;
            $display("FAIL rr_first_done: done=%b id=%0d, required 1 0", done_valid, done_id);
        end
        k = 0;
        while (n_issued < 5 && k < 10) begin
            tick();
            k++;
        end
        n_checks++;
        if (n_issued !== 5) begin
            n_errors++;
            $display("FAIL rr_resume: issued %0d, required 5", n_issued);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int   ord[6] = '{0, 5, 1, 2, 3, 4};
        txn_t t;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_cmd(1'b1, 32'hA000 + 32'(i * 256), 32'hB000 + 32'(i * 256), 32'(i * 4), 1'b0);
        end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (req_valid !== 1'b1 || req_dir !== 1'b1 || req_src !== 32'hA000 ||
                req_dst !== 32'hB000 || req_len !== 32'd0 || req_id !== 8'd0) begin
                n_errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b src=%h id=%0d, required 1 a000 0",
                         c, req_valid, req_src, req_id);
            end
            tick();
        end
        cmd_dir = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_full_out: ready %b, required 0", cmd_ready);
        end
        cmd_dir = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_ready_in: ready %b, required 1", cmd_ready);
        end
        tick();
        send_cmd(1'b0, 32'hA000 + 32'(5 * 256), 32'hB000 + 32'(5 * 256), 32'(5 * 4), 1'b0);
        for (int k = 0; k < 6; k++) begin
            t.id  = 8'(ord[k]);
            t.dir = (ord[k] == 5) ? 1'b0 : 1'b1;
            t.src = 32'hA000 + 32'(ord[k] * 256);
            t.dst = 32'hB000 + 32'(ord[k] * 256);
            t.len = 32'(ord[k] * 4);
            exp_issue_q.push_back(t);
        end
        drain();
    endtask

    task automatic test_wrap();
        int k;
        do_reset();
        req_ready = 1'b1;
        for (int i = 0; i < 253; i++) begin
            send_cmd(i[0], 32'(i), ~32'(i), 32'(i & 7), 1'b1);
            wait_issued(20);
            rsp_valid = 1'b1;
            tick();
            rsp_valid = 1'b0;
            k = 0;
            while (exp_done_q.size() != 0 && k < 10) begin
                tick();
                k++;
            end
        end
        for (int i = 253; i < 257; i++) begin
            if (i == 256) begin
                n_checks++;
                if (cmd_id !== 8'd0) begin
                    n_errors++;
                    $display("FAIL wrap_id: got %0d, required 0", cmd_id);
                end
            end
            send_cmd(1'b0, 32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i), 32'd0, 1'b1);
        end
        wait_issued(20);
        drain();
    endtask

    task automatic test_error_reset();
        do_reset();
        req_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_cmd(1'b0, 32'h500 + 32'(i), 32'h600, 32'd8, 1'b1);
        wait_issued(20);
        tick();
        rsp_valid = 1'b1;
        rsp_error = 1'b1;
        tick();
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_set: got %b, required 1", err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clear: got %b, required 0", err);
        end
        rsp_valid = 1'b1;
        rsp_error = 1'b1;
        clr_err   = 1'b1;
        tick();
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        clr_err   = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_set_wins: got %b, required 1", err);
        end
        for (int i = 0; i < 2; i++) send_cmd(1'b1, 32'h700 + 32'(i), 32'h900, 32'd16, 1'b1);
        wait_issued(20);
        tick();
        req_ready = 1'b0;
        rst_ni    = 1'b0;
        tick();
        n_checks++;
        if ({req_valid, req_dir, req_src, req_dst, req_len, req_id} !== '0 ||
            {done_valid, done_id, err, busy} !== 11'd0 || cmd_id !== 8'd0 || cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset: valid=%b src=%h id=%0d done=%b did=%0d err=%b busy=%b cid=%0d, required all 0",
                     req_valid, req_src, req_id, done_valid, done_id, err, busy, cmd_id);
        end
        rst_ni = 1'b1;
        exp_issue_q.delete();
        exp_done_q.delete();
        exp_next_id = 8'd0;
        rsp_valid = 1'b1;
        rsp_error = 1'b1;
        tick();
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        tick();
        n_checks++;
        if (done_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_rsp: done=%b err=%b busy=%b, required 0 0 0", done_valid, err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_error_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
